// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the CPU/debug memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    CPU = 1'b0,
    DBG = 1'b1
  } port_id_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 15;

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin picker: on a tie the port that did not win last time goes.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last_grant,
  output logic       grant_valid,
  output port_id_t   grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = CPU;
    case (req)
      2'b01:   grant_id = CPU;
      2'b10:   grant_id = DBG;
      2'b11:   grant_id = (last_grant == CPU) ? DBG : CPU;
      default: grant_id = CPU;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and debug accesses onto one memory with a fixed read latency.
// Define MEM_ARB_PERF_EN to add grant/conflict performance counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
`ifdef MEM_ARB_PERF_EN
  input  logic              perf_clr,
  output logic [15:0]       perf_cpu_grants,
  output logic [15:0]       perf_dbg_grants,
  output logic [15:0]       perf_conflicts,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT must be within 1..15");
  end

  localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

  arb_state_t        state_q, state_d;
  port_id_t          last_grant_q, last_grant_d;
  port_id_t          gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;

  logic              grant_valid;
  port_id_t          grant_id;
  logic              grant_fire;
  logic              rd_cap;
  logic [1:0]        cap;
  logic [1:0][DATA_W-1:0] rdata;

  mem_arb_rr u_rr (
    .req         ({dbg_req, cpu_req}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign grant_fire = (state_q == IDLE) && grant_valid;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lat_cnt_d    = lat_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          gnt_d        = grant_id;
          last_grant_d = grant_id;
          if (grant_id == CPU) begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end else begin
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          state_d   = WAIT;
          lat_cnt_d = LAT_INIT;
        end
      end
      WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_grant starts at DBG so the CPU wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= DBG;
      gnt_q        <= CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lat_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lat_cnt_q    <= lat_cnt_d;
    end
  end

  assign rd_cap = (state_q == WAIT) && (lat_cnt_q == 4'd0);
  assign cap[0] = rd_cap && (gnt_q == CPU);
  assign cap[1] = rd_cap && (gnt_q == DBG);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rdata
      logic [DATA_W-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_q <= '0;
        end else if (cap[gi]) begin
          rdata_q <= mem_rdata;
        end
      end
      assign rdata[gi] = rdata_q;
    end
  endgenerate

  assign cpu_rdata = rdata[0];
  assign dbg_rdata = rdata[1];
  assign cpu_ready = (state_q == DONE) && (gnt_q == CPU);
  assign dbg_ack   = (state_q == DONE) && (gnt_q == DBG);

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

`ifdef MEM_ARB_PERF_EN
  logic [2:0]       perf_inc;
  logic [2:0][15:0] perf_cnt;

  assign perf_inc[0] = grant_fire && (grant_id == CPU);
  assign perf_inc[1] = grant_fire && (grant_id == DBG);
  assign perf_inc[2] = (state_q == IDLE) && cpu_req && dbg_req;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_perf
      logic [15:0] cnt_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else if (perf_clr) begin
          cnt_q <= '0;
        end else if (perf_inc[gi] && (cnt_q != 16'hFFFF)) begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
      assign perf_cnt[gi] = cnt_q;
    end
  endgenerate

  assign perf_cpu_grants = perf_cnt[0];
  assign perf_dbg_grants = perf_cnt[1];
  assign perf_conflicts  = perf_cnt[2];
`else
  logic unused_grant_fire;
  assign unused_grant_fire = grant_fire;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expectations, negedge monitors pop and compare.
module tb_mem_port_arbiter;

  localparam int RD_LAT = 2;
  localparam bit P_CPU  = 1'b0;
  localparam bit P_DBG  = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic        cpu_ready;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0, dbg_rdata;
  logic        dbg_ack;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic        perf_clr = 1'b0;
  logic [15:0] perf_cpu_grants, perf_dbg_grants, perf_conflicts;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata),
    .dbg_ack   (dbg_ack),
`ifdef MEM_ARB_PERF_EN
    .perf_clr        (perf_clr),
    .perf_cpu_grants (perf_cpu_grants),
    .perf_dbg_grants (perf_dbg_grants),
    .perf_conflicts  (perf_conflicts),
`endif
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk_data;
    logic [31:0] data;
    int          cyc;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } macc_t;

  resp_t cpu_q[$];
  resp_t dbg_q[$];
  macc_t mem_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Memory model: fixed RD_LAT pipeline, word-indexed by addr[9:2].
  logic [31:0] mem_arr [256];
  logic [31:0] pipe [RD_LAT];
  assign mem_rdata = pipe[RD_LAT-1];

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'hC0DE0000 + 32'(i * 4);
    mem_arr[16] = 32'hDEADBEEF;
    for (int k = 0; k < RD_LAT; k++) pipe[k] = '0;
    forever begin
      @(posedge clk);
      for (int k = RD_LAT - 1; k > 0; k--) pipe[k] <= pipe[k-1];
      pipe[0] <= (mem_en && !mem_we) ? mem_arr[mem_addr[9:2]] : 32'h0;
      if (mem_en && mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: memory-side accesses.
  initial forever begin
    macc_t m;
    @(negedge clk);
    if (mem_en) begin
      if (mem_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL mem_unexpected: got mem_en addr %0h expected no access", mem_addr);
      end else begin
        m = mem_q.pop_front();
        $display("mem access cycle %0d we=%0b addr=%0h wdata=%0h", cyc, mem_we, mem_addr, mem_wdata);
        check("mem_we", 64'(mem_we), 64'(m.we));
        check("mem_addr", 64'(mem_addr), 64'(m.addr));
        if (m.we) check("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
      end
    end
  end

  // Monitor: CPU and debug responses.
  initial forever begin
    resp_t r;
    @(negedge clk);
    if (cpu_ready) begin
      if (cpu_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL cpu_ready_unexpected: got cpu_ready=1 expected 0 (cycle %0d)", cyc);
      end else begin
        r = cpu_q.pop_front();
        $display("cpu_ready cycle %0d rdata=%0h", cyc, cpu_rdata);
        if (r.chk_data) check("cpu_rdata", 64'(cpu_rdata), 64'(r.data));
        if (r.cyc >= 0) check("cpu_ready_cycle", 64'(cyc), 64'(r.cyc));
      end
    end
    if (dbg_ack) begin
      if (dbg_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL dbg_ack_unexpected: got dbg_ack=1 expected 0 (cycle %0d)", cyc);
      end else begin
        r = dbg_q.pop_front();
        $display("dbg_ack cycle %0d rdata=%0h", cyc, dbg_rdata);
        if (r.chk_data) check("dbg_rdata", 64'(dbg_rdata), 64'(r.data));
        if (r.cyc >= 0) check("dbg_ack_cycle", 64'(cyc), 64'(r.cyc));
      end
    end
  end

  task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    macc_t m;
    m.we = we;
    m.addr = addr;
    m.wdata = wdata;
    mem_q.push_back(m);
  endtask

  // Issues one request (called at posedge+1), waits for its pulse, drops req next cycle.
  task automatic access(input bit port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data, input int exp_lat);
    resp_t r;
    bit seen;
    r.chk_data = !we;
    r.data = exp_data;
    r.cyc = (exp_lat < 0) ? -1 : cyc + exp_lat;
    if (port == P_CPU) begin
      cpu_q.push_back(r);
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end else begin
      dbg_q.push_back(r);
      dbg_we = we; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
    end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = (port == P_CPU) ? cpu_ready : dbg_ack;
    end
    if (!seen) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL response_timeout: port %0d addr %0h got no pulse expected one", port, addr);
    end
    @(posedge clk);
    #1;
    if (port == P_CPU) cpu_req = 1'b0;
    else dbg_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    #1;
    check("reset_strobes", 64'({mem_en, mem_we, cpu_ready, dbg_ack}), 64'd0);
    check("reset_cpu_rdata", 64'(cpu_rdata), 64'd0);
    check("reset_dbg_rdata", 64'(dbg_rdata), 64'd0);
    check("reset_mem_addr", 64'(mem_addr), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Single CPU read, ready four cycles after sampling.
    exp_mem(1'b0, 32'h40, 32'h0);
    access(P_CPU, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, RD_LAT + 2);

    // Debug write, ack two cycles after sampling.
    exp_mem(1'b1, 32'h100, 32'h12345678);
    access(P_DBG, 1'b1, 32'h100, 32'h12345678, 32'h0, 2);
    check("cpu_rdata_hold_dbg_wr", 64'(cpu_rdata), 64'h00000000DEADBEEF);

    exp_mem(1'b0, 32'h100, 32'h0);
    access(P_DBG, 1'b0, 32'h100, 32'h0, 32'h12345678, RD_LAT + 2);
    check("cpu_rdata_hold_dbg_rd", 64'(cpu_rdata), 64'h00000000DEADBEEF);

    exp_mem(1'b1, 32'h80, 32'hCAFEF00D);
    access(P_CPU, 1'b1, 32'h80, 32'hCAFEF00D, 32'h0, 2);
    exp_mem(1'b0, 32'h80, 32'h0);
    access(P_DBG, 1'b0, 32'h80, 32'h0, 32'hCAFEF00D, RD_LAT + 2);
    check("cpu_rdata_hold_cpu_wr", 64'(cpu_rdata), 64'h00000000DEADBEEF);

    // Simultaneous requests after reset: CPU first, DBG right after.
    do_reset();
    exp_mem(1'b0, 32'h0, 32'h0);
    exp_mem(1'b0, 32'h4, 32'h0);
    fork
      access(P_CPU, 1'b0, 32'h0, 32'h0, 32'hC0DE0000, RD_LAT + 2);
      access(P_DBG, 1'b0, 32'h4, 32'h0, 32'hC0DE0004, 2 * (RD_LAT + 2) + 1);
    join
`ifdef MEM_ARB_PERF_EN
    check("perf_conflicts_simul", 64'(perf_conflicts), 64'd1);
    check("perf_cpu_grants_simul", 64'(perf_cpu_grants), 64'd1);
`endif

    // Sustained contention: both keep requesting, grants must alternate.
    do_reset();
    exp_mem(1'b0, 32'h10, 32'h0);
    exp_mem(1'b0, 32'h20, 32'h0);
    exp_mem(1'b0, 32'h14, 32'h0);
    exp_mem(1'b0, 32'h24, 32'h0);
    exp_mem(1'b0, 32'h18, 32'h0);
    exp_mem(1'b0, 32'h28, 32'h0);
    fork
      begin
        access(P_CPU, 1'b0, 32'h10, 32'h0, 32'hC0DE0010, RD_LAT + 2);
        access(P_CPU, 1'b0, 32'h14, 32'h0, 32'hC0DE0014, -1);
        access(P_CPU, 1'b0, 32'h18, 32'h0, 32'hC0DE0018, -1);
      end
      begin
        access(P_DBG, 1'b0, 32'h20, 32'h0, 32'hC0DE0020, 2 * (RD_LAT + 2) + 1);
        access(P_DBG, 1'b0, 32'h24, 32'h0, 32'hC0DE0024, -1);
        access(P_DBG, 1'b0, 32'h28, 32'h0, 32'hC0DE0028, -1);
      end
    join
`ifdef MEM_ARB_PERF_EN
    check("perf_cpu_grants", 64'(perf_cpu_grants), 64'd3);
    check("perf_dbg_grants", 64'(perf_dbg_grants), 64'd3);
    check("perf_conflicts", 64'(perf_conflicts), 64'd5);
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
    check("perf_clr", 64'({perf_cpu_grants, perf_dbg_grants, perf_conflicts}), 64'd0);
`endif

    // Reset while a CPU read sits in WAIT: no stale ready afterwards.
    exp_mem(1'b0, 32'h44, 32'h0);
    cpu_we = 1'b0; cpu_addr = 32'h44; cpu_req = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    check("rst_mid_mem_en", 64'(mem_en), 64'd0);
    check("rst_mid_cpu_ready", 64'(cpu_ready), 64'd0);
    check("rst_mid_cpu_rdata", 64'(cpu_rdata), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    exp_mem(1'b1, 32'h84, 32'h5A5A5A5A);
    access(P_CPU, 1'b1, 32'h84, 32'h5A5A5A5A, 32'h0, 2);

    // Early drop during WAIT: access still completes exactly once.
    begin
      resp_t r;
      r.chk_data = 1'b1;
      r.data = 32'hC0DE0048;
      r.cyc = cyc + RD_LAT + 2;
      cpu_q.push_back(r);
    end
    exp_mem(1'b0, 32'h48, 32'h0);
    cpu_we = 1'b0; cpu_addr = 32'h48; cpu_req = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    cpu_req = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("early_drop_ready_seen", 64'(cpu_q.size()), 64'd0);

    check("cpu_q_empty", 64'(cpu_q.size()), 64'd0);
    check("dbg_q_empty", 64'(dbg_q.size()), 64'd0);
    check("mem_q_empty", 64'(mem_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
